// File: rtl/uart_tx_arbiter_if.sv
// Byte-source handshakes, baud-generator link and serial-line status
// shared between the UART transmit arbiter and its surroundings.
interface uart_tx_arbiter_if;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic       bps_tick;
  logic       bps_en;
  logic       txd;
  logic       busy;
  logic       gnt_id;
  logic       tx_done;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, bps_tick,
    input  req0_ready, req1_ready, bps_en, txd, busy, gnt_id, tx_done
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, bps_tick,
    output req0_ready, req1_ready, bps_en, txd, busy, gnt_id, tx_done
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Two-port round-robin UART transmitter driving one serial line, paced by an
// external baud tick generator that it enables for the duration of a frame.
module uart_tx_arbiter #(
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              RST,
  uart_tx_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } state_t;

  localparam logic       PAR_EN    = (PARITY != 0);
  localparam logic       PAR_ODD   = (PARITY == 2);
  localparam logic [1:0] STOP_LAST = 2'(STOP_BITS);

  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  state_t     state_r, state_s;
  logic       txd_r, txd_s;
  logic       bps_en_r, bps_en_s;
  logic       tx_done_r, tx_done_s;
  logic       gnt_r, gnt_s;
  logic       last_r, last_s;
  logic [7:0] shift_r, shift_s;
  logic       par_r, par_s;
  logic [3:0] bit_cnt_r, bit_cnt_s;
  logic [1:0] stop_cnt_r, stop_cnt_s;
  logic       rdy0_s, rdy1_s;
  logic       tick_s;

  // A port loses a tie only if it owned the previous frame.
  assign rdy0_s = (state_r == ST_IDLE) & bus.req0_valid & (~bus.req1_valid | (last_r != 1'b0));
  assign rdy1_s = (state_r == ST_IDLE) & bus.req1_valid & (~bus.req0_valid | (last_r != 1'b1));
  assign tick_s = bus.bps_tick;

  // Next-state and next-register computation for the frame sequencer.
  always_comb begin
    state_s    = state_r;
    txd_s      = txd_r;
    bps_en_s   = bps_en_r;
    tx_done_s  = 1'b0;
    gnt_s      = gnt_r;
    last_s     = last_r;
    shift_s    = shift_r;
    par_s      = par_r;
    bit_cnt_s  = bit_cnt_r;
    stop_cnt_s = stop_cnt_r;
    case (state_r)
      ST_IDLE: begin
        txd_s = 1'b1;
        if (rdy0_s) begin
          shift_s  = bus.req0_data;
          par_s    = parity_bit(bus.req0_data, PAR_ODD);
          gnt_s    = 1'b0;
          last_s   = 1'b0;
          bps_en_s = 1'b1;
          state_s  = ST_SYNC;
        end else if (rdy1_s) begin
          shift_s  = bus.req1_data;
          par_s    = parity_bit(bus.req1_data, PAR_ODD);
          gnt_s    = 1'b1;
          last_s   = 1'b1;
          bps_en_s = 1'b1;
          state_s  = ST_SYNC;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SYNC: begin
        // First tick after enable lands mid-period; it only aligns the frame.
        if (tick_s) begin
          txd_s   = 1'b0;
          state_s = ST_START;
        end else begin
          state_s = ST_SYNC;
        end
      end
      ST_START: begin
        if (tick_s) begin
          txd_s     = shift_r[0];
          shift_s   = {1'b0, shift_r[7:1]};
          bit_cnt_s = 4'd1;
          state_s   = ST_DATA;
        end else begin
          state_s = ST_START;
        end
      end
      ST_DATA: begin
        if (tick_s) begin
          if (bit_cnt_r < 4'd8) begin
            txd_s     = shift_r[0];
            shift_s   = {1'b0, shift_r[7:1]};
            bit_cnt_s = bit_cnt_r + 4'd1;
          end else if (PAR_EN) begin
            txd_s   = par_r;
            state_s = ST_PARITY;
          end else begin
            txd_s      = 1'b1;
            stop_cnt_s = 2'd1;
            state_s    = ST_STOP;
          end
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (tick_s) begin
          txd_s      = 1'b1;
          stop_cnt_s = 2'd1;
          state_s    = ST_STOP;
        end else begin
          state_s = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (tick_s) begin
          if (stop_cnt_r < STOP_LAST) begin
            stop_cnt_s = stop_cnt_r + 2'd1;
          end else begin
            bps_en_s  = 1'b0;
            tx_done_s = 1'b1;
            state_s   = ST_IDLE;
          end
        end else begin
          state_s = ST_STOP;
        end
      end
      default: begin
        txd_s    = 1'b1;
        bps_en_s = 1'b0;
        state_s  = ST_IDLE;
      end
    endcase
  end

  // Sequencer state and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_r    <= ST_IDLE;
      txd_r      <= 1'b1;
      bps_en_r   <= 1'b0;
      tx_done_r  <= 1'b0;
      gnt_r      <= 1'b0;
      last_r     <= 1'b1;
      shift_r    <= 8'h00;
      par_r      <= 1'b0;
      bit_cnt_r  <= 4'd0;
      stop_cnt_r <= 2'd0;
    end else begin
      state_r    <= state_s;
      txd_r      <= txd_s;
      bps_en_r   <= bps_en_s;
      tx_done_r  <= tx_done_s;
      gnt_r      <= gnt_s;
      last_r     <= last_s;
      shift_r    <= shift_s;
      par_r      <= par_s;
      bit_cnt_r  <= bit_cnt_s;
      stop_cnt_r <= stop_cnt_s;
    end
  end

  assign bus.req0_ready = rdy0_s;
  assign bus.req1_ready = rdy1_s;
  assign bus.bps_en     = bps_en_r;
  assign bus.txd        = txd_r;
  assign bus.busy       = (state_r != ST_IDLE);
  assign bus.gnt_id     = gnt_r;
  assign bus.tx_done    = tx_done_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: four parameter variants, each paced by
// a 16-cycle baud generator model that ticks mid-period and idles at zero.
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       RST = 1'b1;
  logic [1:0] sel = 2'd0;
  logic       r0v = 1'b0, r1v = 1'b0, man_tick = 1'b0;
  logic [7:0] r0d = 8'h00, r1d = 8'h00;
  int         checks = 0;
  int         errors = 0;

  logic [3:0] txd_v, en_v, busy_v, gnt_v, done_v, rdy0_v, rdy1_v, tick_v;

  always #5 clk = ~clk;

  uart_tx_arbiter_if ifs[4] ();

  for (genvar k = 0; k < 4; k++) begin : g_dut
    logic [3:0] gcnt;
    logic       gtick;

    uart_tx_arbiter #(
      .PARITY   ((k == 1) ? 1 : ((k == 2) ? 2 : 0)),
      .STOP_BITS((k == 3) ? 2 : 1)
    ) u_dut (
      .clk(clk),
      .RST(RST),
      .bus(ifs[k])
    );

    // Baud generator model: counter held at zero while disabled.
    always @(posedge clk or posedge RST) begin
      if (RST) begin
        gcnt  <= 4'd0;
        gtick <= 1'b0;
      end else if (!ifs[k].bps_en) begin
        gcnt  <= 4'd0;
        gtick <= 1'b0;
      end else begin
        gcnt  <= gcnt + 4'd1;
        gtick <= (gcnt == 4'd7);
      end
    end

    assign ifs[k].req0_valid = (sel == k) && r0v;
    assign ifs[k].req1_valid = (sel == k) && r1v;
    assign ifs[k].req0_data  = r0d;
    assign ifs[k].req1_data  = r1d;
    assign ifs[k].bps_tick   = gtick | ((sel == k) && man_tick);

    assign txd_v[k]  = ifs[k].txd;
    assign en_v[k]   = ifs[k].bps_en;
    assign busy_v[k] = ifs[k].busy;
    assign gnt_v[k]  = ifs[k].gnt_id;
    assign done_v[k] = ifs[k].tx_done;
    assign rdy0_v[k] = ifs[k].req0_ready;
    assign rdy1_v[k] = ifs[k].req1_ready;
    assign tick_v[k] = ifs[k].bps_tick;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_accept(input logic v0, input logic v1, input logic [7:0] d0,
                           input logic [7:0] d1, input logic exp_gnt, input logic with_tick);
    @(negedge clk);
    r0v = v0; r1v = v1; r0d = d0; r1d = d1; man_tick = with_tick;
    #1;
    chk("req0_ready", rdy0_v[sel], (exp_gnt == 1'b0) ? 32'd1 : 32'd0);
    chk("req1_ready", rdy1_v[sel], (exp_gnt == 1'b1) ? 32'd1 : 32'd0);
    @(posedge clk);
    #1;
    r0v = 1'b0; r1v = 1'b0; man_tick = 1'b0;
    chk("acc_busy", busy_v[sel], 32'd1);
    chk("acc_gnt", gnt_v[sel], {31'd0, exp_gnt});
    chk("acc_bps_en", en_v[sel], 32'd1);
    chk("acc_txd", txd_v[sel], 32'd1);
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick_v[sel] && n < 40);
    chk("tick_seen", tick_v[sel], 32'd1);
  endtask

  task automatic run_frame(input logic [7:0] b, input int nticks, input logic has_par,
                           input logic par_bit, input int stop_at);
    logic exp_txd;
    for (int i = 1; i <= stop_at; i++) begin
      wait_tick();
      @(posedge clk);
      #1;
      if (i == 1) exp_txd = 1'b0;
      else if (i <= 9) exp_txd = b[i-2];
      else if (i == 10 && has_par) exp_txd = par_bit;
      else exp_txd = 1'b1;
      chk($sformatf("txd_t%0d", i), txd_v[sel], {31'd0, exp_txd});
      chk($sformatf("done_t%0d", i), done_v[sel], (i == nticks) ? 32'd1 : 32'd0);
      chk($sformatf("en_t%0d", i), en_v[sel], (i == nticks) ? 32'd0 : 32'd1);
      chk($sformatf("busy_t%0d", i), busy_v[sel], (i == nticks) ? 32'd0 : 32'd1);
    end
    if (stop_at == nticks) begin
      @(posedge clk);
      #1;
      chk("done_pulse_end", done_v[sel], 32'd0);
    end
  endtask

  initial begin
    logic saw_done;
    // Reset state
    #12;
    chk("rst_txd", txd_v[0], 32'd1);
    chk("rst_en", en_v[0], 32'd0);
    chk("rst_busy", busy_v[0], 32'd0);
    chk("rst_done", done_v[0], 32'd0);
    chk("rst_gnt", gnt_v[0], 32'd0);
    @(negedge clk);
    RST = 1'b0;

    // Round-robin: tie from reset goes to port 0, then strict alternation
    sel = 2'd0;
    do_accept(1'b1, 1'b1, 8'h3C, 8'hC3, 1'b0, 1'b0);
    run_frame(8'h3C, 11, 1'b0, 1'b0, 11);
    do_accept(1'b1, 1'b1, 8'h3C, 8'hC3, 1'b1, 1'b0);
    run_frame(8'hC3, 11, 1'b0, 1'b0, 11);
    do_accept(1'b1, 1'b1, 8'h81, 8'h7E, 1'b0, 1'b0);
    run_frame(8'h81, 11, 1'b0, 1'b0, 11);

    // 0xA5 from port 0, data input changed after accept must not matter
    do_accept(1'b1, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b0);
    r0d = 8'hFF;
    run_frame(8'hA5, 11, 1'b0, 1'b0, 11);
    chk("gnt_hold", gnt_v[0], 32'd0);

    // Ticks in IDLE and in the accept cycle are ignored
    @(negedge clk);
    man_tick = 1'b1;
    @(posedge clk);
    #1;
    man_tick = 1'b0;
    chk("idle_tick_busy", busy_v[0], 32'd0);
    chk("idle_tick_txd", txd_v[0], 32'd1);
    do_accept(1'b1, 1'b0, 8'h96, 8'h00, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk("sync_hold_txd", txd_v[0], 32'd1);
    run_frame(8'h96, 11, 1'b0, 1'b0, 11);

    // Reset during data bit 4 aborts the frame
    do_accept(1'b1, 1'b0, 8'hEF, 8'h00, 1'b0, 1'b0);
    run_frame(8'hEF, 11, 1'b0, 1'b0, 6);
    chk("bit4_low", txd_v[0], 32'd0);
    #2;
    RST = 1'b1;
    #1;
    chk("abort_txd", txd_v[0], 32'd1);
    chk("abort_en", en_v[0], 32'd0);
    chk("abort_busy", busy_v[0], 32'd0);
    chk("abort_gnt", gnt_v[0], 32'd0);
    repeat (2) @(negedge clk);
    RST = 1'b0;
    saw_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done_v[0]) saw_done = 1'b1;
    end
    chk("abort_no_done", {31'd0, saw_done}, 32'd0);
    do_accept(1'b0, 1'b1, 8'h00, 8'h5A, 1'b1, 1'b0);
    run_frame(8'h5A, 11, 1'b0, 1'b0, 11);

    // Even and odd parity on 0x07
    sel = 2'd1;
    do_accept(1'b1, 1'b0, 8'h07, 8'h00, 1'b0, 1'b0);
    run_frame(8'h07, 12, 1'b1, 1'b1, 12);
    sel = 2'd2;
    do_accept(1'b1, 1'b0, 8'h07, 8'h00, 1'b0, 1'b0);
    run_frame(8'h07, 12, 1'b1, 1'b0, 12);

    // Two stop bits
    sel = 2'd3;
    do_accept(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    run_frame(8'h00, 12, 1'b0, 1'b0, 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
